hash_job_scheduler: RTL
=======================

// Module: hash_job_scheduler
// PURPOSE
//  Shares one hash core among NREQ message sources. Round-robin arbitration picks a source;
//  sequences the core (start, byte stream, end-of-file, digest wait); returns digest with done/ack.
//  Sits between the message-source front-ends and the hash core's F_dr/F_rtr/End_of_File/H_ready ports.
// PARAMETERS
//  NREQ     4     number of requesters (2..8)
//  DATA_W   8     message word width forwarded to the core
//  DIG_W    64    digest width captured from the core
//  TMO_CYC  4096  watchdog limit in cycles, used only with HASH_TIMEOUT_EN
// PORTS
//  clk          in   1              clock
//  rst_n        in   1              async active-low reset
//  req_i        in   NREQ           job request, level, one bit per source
//  empty_i      in   NREQ           job has zero-length message; sampled at grant
//  src_data_i   in   NREQ*DATA_W    per-source data, packed, source k at [k*DATA_W +: DATA_W]
//  src_valid_i  in   NREQ           per-source data valid
//  src_last_i   in   NREQ           qualifies last word of the message
//  src_ready_o  out  NREQ           per-source ready; only the granted bit may be 1
//  grant_o      out  NREQ           one-hot owner of the core, 0 when IDLE
//  done_o       out  NREQ           digest valid for granted source, held until ack
//  done_ack_i   in   NREQ           source consumed digest
//  err_o        out  1              job aborted by watchdog (qualified by done_o)
//  digest_o     out  DIG_W          captured digest
//  busy_o       out  1              state != IDLE
//  core_start_o out  1              1-cycle pulse, resets the core's control FSM
//  core_data_o  out  DATA_W         = src_data of granted source
//  core_dr_o    out  1              F_dr to core
//  core_rtr_i   in   1              F_rtr from core
//  core_eof_o   out  1              End_of_File to core
//  core_hrdy_i  in   1              H_ready from core
//  core_dig_i   in   DIG_W          core digest
// BEHAVIOUR
//  Reset: state IDLE, rr pointer 0, all outputs 0, digest_o 0. Reset mid-job drops job silently.
//  FSM: IDLE -> START -> STREAM -> EOF -> WAIT_H -> DELIVER -> IDLE.
//  IDLE: if |req_i, grant first requester at or after ptr (wrapping); latch grant; -> START.
//  START: core_start_o=1 one cycle; -> EOF if empty_i[g] latched at grant, else STREAM.
//  STREAM: core_dr_o=src_valid[g]; src_ready[g]=core_rtr_i; transfer = valid&rtr;
//    transfer with src_last[g] -> EOF. No bytes forwarded in any other state.
//  EOF: core_eof_o=1, core_dr_o=0; when core_rtr_i=1 -> WAIT_H (EOF accepted that cycle).
//  WAIT_H: on core_hrdy_i=1 capture core_dig_i into digest_o -> DELIVER.
//  DELIVER: done_o[g]=1 until done_ack_i[g]; on ack: ptr=g+1 mod NREQ, grant cleared -> IDLE.
//  req_i sampled only in IDLE; deasserting req mid-job does not abort. Ack from non-granted source ignored.
//  Back-to-back: a request pending at ack is granted the cycle after IDLE is entered (1 idle cycle).
//  Latency: grant->core_start 1 cycle; H_ready->done_o 1 cycle.
// CONFIGURATION
//  HASH_TIMEOUT_EN defined: counter clears on every transfer/EOF accept/state change; reaching
//   TMO_CYC in STREAM, EOF or WAIT_H -> DELIVER with err_o=1, digest_o=0, core_start_o pulsed
//   on the abort cycle to reset the core. Undefined: no counter, err_o tied 0, waits forever.
// STRUCTURE
//  hash_sched_pkg: state_t enum (IDLE..DELIVER), NREQ_MAX, clog2-derived pointer width helper.
//  Sub-module rr_arbiter: combinational req+ptr -> one-hot grant; scheduler owns ptr register.
// TESTING
//  1 req_i=0001, 3 bytes A1,B2,C3 last on C3 -> core sees 3 dr&rtr transfers, one eof accept,
//    core_hrdy with dig=0x0123456789ABCDEF -> done_o=0001, digest_o=0x0123456789ABCDEF.
//  2 req_i=1111 held, ack immediately each time -> grants 0001,0010,0100,1000,0001 in order.
//  3 empty_i[2]=1, req_i=0100 -> START then EOF, zero core_dr_o pulses, done_o=0100.
//  4 source stalls valid 5 cycles mid-message -> core_dr_o low 5 cycles, byte order intact.
//  5 rst_n low during WAIT_H -> all outputs 0 next edge, ptr=0, next req granted cleanly.
//  6 HASH_TIMEOUT_EN, TMO_CYC=16, core_hrdy never -> after 16 cycles err_o=1, done_o set, start pulse.

Source files
------------

// File: rtl/hash_job_scheduler_pkg.sv
// Shared types and helpers for the hash job scheduler: FSM state encoding and
// pointer-width derivation for the round-robin arbiter.
package hash_job_scheduler_pkg;

    localparam int unsigned NREQ_MAX = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        STREAM,
        EOF,
        WAIT_H,
        DELIVER
    } state_t;

    // Width of a requester index; NREQ is supported from 2 up to NREQ_MAX.
    function automatic int unsigned ptr_w(input int unsigned n);
        int unsigned m;
        m = (n > NREQ_MAX) ? NREQ_MAX : n;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/hash_job_scheduler_if.sv
// Source-side and core-side signals of the hash job scheduler.
// master: scheduler view; slave: message sources + hash core view.
interface hash_job_scheduler_if #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DIG_W  = 64
);
    logic [NREQ-1:0]        req_i;
    logic [NREQ-1:0]        empty_i;
    logic [NREQ*DATA_W-1:0] src_data_i;
    logic [NREQ-1:0]        src_valid_i;
    logic [NREQ-1:0]        src_last_i;
    logic [NREQ-1:0]        src_ready_o;
    logic [NREQ-1:0]        grant_o;
    logic [NREQ-1:0]        done_o;
    logic [NREQ-1:0]        done_ack_i;
    logic                   err_o;
    logic [DIG_W-1:0]       digest_o;
    logic                   busy_o;
    logic                   core_start_o;
    logic [DATA_W-1:0]      core_data_o;
    logic                   core_dr_o;
    logic                   core_rtr_i;
    logic                   core_eof_o;
    logic                   core_hrdy_i;
    logic [DIG_W-1:0]       core_dig_i;

    modport master (
        input  req_i, empty_i, src_data_i, src_valid_i, src_last_i, done_ack_i,
               core_rtr_i, core_hrdy_i, core_dig_i,
        output src_ready_o, grant_o, done_o, err_o, digest_o, busy_o,
               core_start_o, core_data_o, core_dr_o, core_eof_o
    );

    modport slave (
        output req_i, empty_i, src_data_i, src_valid_i, src_last_i, done_ack_i,
               core_rtr_i, core_hrdy_i, core_dig_i,
        input  src_ready_o, grant_o, done_o, err_o, digest_o, busy_o,
               core_start_o, core_data_o, core_dr_o, core_eof_o
    );
endinterface

// File: rtl/hash_job_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
// Returns both the one-hot grant and its binary index.
module hash_job_scheduler_rr_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [PTR_W-1:0] gnt_idx
);
    int   idx;
    logic found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < int'(NREQ); i++) begin
            idx = (int'(ptr) + i) % int'(NREQ);
            if (!found && req[PTR_W'(idx)]) begin
                gnt[PTR_W'(idx)] = 1'b1;
                gnt_idx          = PTR_W'(idx);
                found            = 1'b1;
            end
        end
    end
endmodule

// File: rtl/hash_job_scheduler.sv
// Shares one hash core among NREQ sources: round-robin grant, then start/stream/EOF/
// digest-wait sequencing with done/ack handoff. Optional watchdog: HASH_TIMEOUT_EN.
module hash_job_scheduler
    import hash_job_scheduler_pkg::*;
#(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DIG_W  = 64
`ifdef HASH_TIMEOUT_EN
   ,parameter int unsigned TMO_CYC = 4096
`endif
) (
    input logic                  clk,
    input logic                  rst_n,
    hash_job_scheduler_if.master bus
);
    localparam int unsigned PTR_W = ptr_w(NREQ);

    state_t            state;
    logic [PTR_W-1:0]  ptr_q, g_idx_q, arb_idx;
    logic [NREQ-1:0]   grant_q, done_q, arb_gnt;
    logic [DIG_W-1:0]  digest_q;
    logic              empty_q, start_q, eof_q, busy_q;
    logic              xfer_c, eof_acc_c, ack_c;

    hash_job_scheduler_rr_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) u_arb (
        .req     (bus.req_i),
        .ptr     (ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    assign xfer_c    = (state == STREAM) & bus.src_valid_i[g_idx_q] & bus.core_rtr_i;
    assign eof_acc_c = (state == EOF) & bus.core_rtr_i;
    assign ack_c     = |(bus.done_ack_i & grant_q);

    // Byte path is a straight pass-through from the owner; only STREAM lets it move.
    assign bus.core_data_o  = bus.src_data_i[32'(g_idx_q)*DATA_W +: DATA_W];
    assign bus.core_dr_o    = (state == STREAM) & bus.src_valid_i[g_idx_q];
    assign bus.src_ready_o  = grant_q & {NREQ{(state == STREAM) & bus.core_rtr_i}};
    assign bus.grant_o      = grant_q;
    assign bus.done_o       = done_q;
    assign bus.digest_o     = digest_q;
    assign bus.busy_o       = busy_q;
    assign bus.core_start_o = start_q;
    assign bus.core_eof_o   = eof_q;

`ifdef HASH_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TMO_CYC + 1);

    logic [TMO_W-1:0] tmo_q;
    logic             err_q, waiting_c, advance_c, tmo_hit_c;

    assign waiting_c = state inside {STREAM, EOF, WAIT_H};
    assign advance_c = xfer_c | eof_acc_c | ((state == WAIT_H) & bus.core_hrdy_i);
    assign tmo_hit_c = waiting_c & ~advance_c & (tmo_q == TMO_W'(TMO_CYC - 1));
    assign bus.err_o = err_q;

    // Watchdog restarts on any forward progress and whenever the FSM is not waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                  tmo_q <= '0;
        else if (!waiting_c || advance_c || tmo_hit_c) tmo_q <= '0;
        else                                         tmo_q <= tmo_q + TMO_W'(1);
    end
`else
    assign bus.err_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr_q    <= '0;
            g_idx_q  <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            digest_q <= '0;
            empty_q  <= 1'b0;
            start_q  <= 1'b0;
            eof_q    <= 1'b0;
            busy_q   <= 1'b0;
`ifdef HASH_TIMEOUT_EN
            err_q    <= 1'b0;
`endif
        end else begin
            start_q <= 1'b0;
`ifdef HASH_TIMEOUT_EN
            // Abort: hand an errored empty digest back and re-start the core to clear it.
            if (tmo_hit_c) begin
                state    <= DELIVER;
                err_q    <= 1'b1;
                digest_q <= '0;
                done_q   <= grant_q;
                start_q  <= 1'b1;
                eof_q    <= 1'b0;
            end else
`endif
            case (state)
                IDLE: if (|bus.req_i) begin
                    grant_q <= arb_gnt;
                    g_idx_q <= arb_idx;
                    empty_q <= |(bus.empty_i & arb_gnt);
                    start_q <= 1'b1;
                    busy_q  <= 1'b1;
                    state   <= START;
                end
                START: if (empty_q) begin
                    eof_q <= 1'b1;
                    state <= EOF;
                end else begin
                    state <= STREAM;
                end
                STREAM: if (xfer_c && bus.src_last_i[g_idx_q]) begin
                    eof_q <= 1'b1;
                    state <= EOF;
                end
                EOF: if (eof_acc_c) begin
                    eof_q <= 1'b0;
                    state <= WAIT_H;
                end
                WAIT_H: if (bus.core_hrdy_i) begin
                    digest_q <= bus.core_dig_i;
                    done_q   <= grant_q;
                    state    <= DELIVER;
                end
                DELIVER: if (ack_c) begin
                    ptr_q   <= (g_idx_q == PTR_W'(NREQ - 1)) ? '0 : g_idx_q + PTR_W'(1);
                    grant_q <= '0;
                    done_q  <= '0;
                    busy_q  <= 1'b0;
`ifdef HASH_TIMEOUT_EN
                    err_q   <= 1'b0;
`endif
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
